// File: rtl/pwm_pkg.sv
// Shared types, widths and the saturating step helper for the PWM duty ramp.
package pwm_pkg;

    localparam int unsigned PWM_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    // One step from cur toward tgt; never overshoots, wraps or underflows.
    function automatic logic [PWM_W-1:0] step_toward(
        input logic [PWM_W-1:0] cur,
        input logic [PWM_W-1:0] tgt,
        input logic [PWM_W-1:0] stp
    );
        logic [PWM_W:0] diff;
        diff        = '0;
        step_toward = cur;
        if (tgt > cur) begin
            diff        = {1'b0, tgt} - {1'b0, cur};
            step_toward = (diff <= {1'b0, stp}) ? tgt : cur + stp;
        end else if (tgt < cur) begin
            diff        = {1'b0, cur} - {1'b0, tgt};
            step_toward = (diff <= {1'b0, stp}) ? tgt : cur - stp;
        end
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running period counter with a period shadow register; tick_c marks the
// last clock of each period, matching the downstream PWM generator.
module pwm_period_tick
    import pwm_pkg::*;
#(
    parameter int unsigned W = PWM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable_i,
    input  logic [W-1:0] period_i,
    output logic [W-1:0] period_o,
    output logic         tick_c
);

    localparam int unsigned W1 = W + 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] period_q;

    // cnt >= period-1 evaluated as cnt+1 >= period so period 0/1 ticks every cycle
    assign tick_c   = enable_i && (({1'b0, cnt_q} + W1'(1)) >= {1'b0, period_q});
    assign period_o = period_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else if (tick_c) begin
            cnt_q    <= '0;
            period_q <= period_i;
        end else if (enable_i) begin
            cnt_q    <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Ramps the PWM duty toward a commanded target, one step per hold_eff periods.
// Optional build macro PWM_RAMP_RETARGET_EN: accept new commands during RAMP.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned W = PWM_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [W-1:0] period_in,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_target,
    input  logic [W-1:0] cmd_step,
    input  logic [W-1:0] cmd_hold,
    output logic [W-1:0] period,
    output logic [W-1:0] duty,
    output logic         busy,
    output logic         done
);

`ifdef PWM_RAMP_RETARGET_EN
    localparam bit RetargetEn = 1'b1;
`else
    localparam bit RetargetEn = 1'b0;
`endif

    ramp_state_t  state_q;
    logic [W-1:0] duty_q;
    logic [W-1:0] target_q;
    logic [W-1:0] step_q;
    logic [W-1:0] hold_q;
    logic [W-1:0] hold_cnt_q;
    logic         busy_q;
    logic         done_q;
    logic         cmd_ready_q;

    logic         tick_c;
    logic         accept_c;
    logic [W-1:0] target_eff_d;
    logic [W-1:0] step_eff_d;
    logic [W-1:0] hold_eff_d;
    logic [W-1:0] duty_step_d;

    pwm_period_tick #(.W(W)) u_period_tick (
        .clk      (clk),
        .rst_n    (reset_n),
        .enable_i (enable),
        .period_i (period_in),
        .period_o (period),
        .tick_c   (tick_c)
    );

    assign accept_c     = cmd_valid && cmd_ready_q;
    assign target_eff_d = (cmd_target > period_in) ? period_in : cmd_target;
    assign step_eff_d   = (cmd_step == '0) ? W'(1) : cmd_step;
    assign hold_eff_d   = (cmd_hold == '0) ? W'(1) : cmd_hold;
    assign duty_step_d  = W'(step_toward(PWM_W'(duty_q), PWM_W'(target_q), PWM_W'(step_q)));

    // Accept takes priority over a coincident tick; no step in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            target_q    <= '0;
            step_q      <= '0;
            hold_q      <= '0;
            hold_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            if (accept_c) begin
                target_q   <= target_eff_d;
                step_q     <= step_eff_d;
                hold_q     <= hold_eff_d;
                hold_cnt_q <= hold_eff_d;
                if (target_eff_d == duty_q) begin
                    done_q      <= 1'b1;
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end else begin
                    state_q     <= RAMP;
                    busy_q      <= 1'b1;
                    cmd_ready_q <= RetargetEn;
                end
            end else if (state_q == RAMP && tick_c) begin
                if (hold_cnt_q > W'(1)) begin
                    hold_cnt_q <= hold_cnt_q - W'(1);
                end else begin
                    duty_q     <= duty_step_d;
                    hold_cnt_q <= hold_q;
                    if (duty_step_d == target_q) begin
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign duty      = duty_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = cmd_ready_q;

endmodule
